// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: one load/store at a time, sub-word stores done as
// read-modify-write through an external store-data mux, loads extracted and extended.
module mem_access_ctrl #(
  parameter int CPU_WIDTH    = 32,
  parameter int MEM_OP_WIDTH = 4,
  parameter logic [MEM_OP_WIDTH-1:0] MEM_NO  = MEM_OP_WIDTH'(0),
  parameter logic [MEM_OP_WIDTH-1:0] MEM_LB  = MEM_OP_WIDTH'(1),
  parameter logic [MEM_OP_WIDTH-1:0] MEM_LH  = MEM_OP_WIDTH'(2),
  parameter logic [MEM_OP_WIDTH-1:0] MEM_LW  = MEM_OP_WIDTH'(3),
  parameter logic [MEM_OP_WIDTH-1:0] MEM_LBU = MEM_OP_WIDTH'(4),
  parameter logic [MEM_OP_WIDTH-1:0] MEM_LHU = MEM_OP_WIDTH'(5),
  parameter logic [MEM_OP_WIDTH-1:0] MEM_SB  = MEM_OP_WIDTH'(6),
  parameter logic [MEM_OP_WIDTH-1:0] MEM_SH  = MEM_OP_WIDTH'(7),
  parameter logic [MEM_OP_WIDTH-1:0] MEM_SW  = MEM_OP_WIDTH'(8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [MEM_OP_WIDTH-1:0] mem_op,
  input  logic [CPU_WIDTH-1:0]    mem_addr,
  output logic [CPU_WIDTH-1:0]    rmw_rdata,
  input  logic [CPU_WIDTH-1:0]    rmw_wdata,
  output logic                    rsp_valid,
  output logic [CPU_WIDTH-1:0]    load_data,
  output logic                    misalign_err,
  output logic                    dmem_en,
  output logic                    dmem_we,
  output logic [CPU_WIDTH-1:0]    dmem_addr,
  output logic [CPU_WIDTH-1:0]    dmem_wdata,
  input  logic [CPU_WIDTH-1:0]    dmem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [MEM_OP_WIDTH-1:0] op_q, op_d;
  logic [CPU_WIDTH-1:0]    addr_q, addr_d;
  logic                    err_q, err_d;
  logic [CPU_WIDTH-1:0]    rdata_q, rdata_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    misalign_err_q, misalign_err_d;
  logic                    dmem_en_q, dmem_en_d;
  logic                    dmem_we_q, dmem_we_d;
  logic [CPU_WIDTH-1:0]    load_data_q, load_data_d;

  function automatic logic is_misaligned(input logic [MEM_OP_WIDTH-1:0] op,
                                         input logic [CPU_WIDTH-1:0] addr);
    logic mis;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = addr[0];
      MEM_LW, MEM_SW:          mis = (addr[1:0] != 2'b00);
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_load(input logic [MEM_OP_WIDTH-1:0] op);
    logic ld;
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: ld = 1'b1;
      default:                                  ld = 1'b0;
    endcase
    return ld;
  endfunction

  function automatic logic is_sub_store(input logic [MEM_OP_WIDTH-1:0] op);
    logic ss;
    case (op)
      MEM_SB, MEM_SH: ss = 1'b1;
      default:        ss = 1'b0;
    endcase
    return ss;
  endfunction

  // Byte/half lane select followed by sign or zero extension; stores yield zero.
  function automatic logic [CPU_WIDTH-1:0] extract_load(input logic [MEM_OP_WIDTH-1:0] op,
                                                        input logic [1:0] lane,
                                                        input logic [CPU_WIDTH-1:0] word);
    logic [7:0]           b;
    logic [15:0]          h;
    logic [CPU_WIDTH-1:0] res;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      MEM_LB:  res = {{(CPU_WIDTH-8){b[7]}}, b};
      MEM_LBU: res = {{(CPU_WIDTH-8){1'b0}}, b};
      MEM_LH:  res = {{(CPU_WIDTH-16){h[15]}}, h};
      MEM_LHU: res = {{(CPU_WIDTH-16){1'b0}}, h};
      MEM_LW:  res = word;
      default: res = {CPU_WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  // Next-state, latched request fields and the next values of every registered output.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    err_d          = err_q;
    rdata_d        = rdata_q;
    load_data_d    = {CPU_WIDTH{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d   = mem_op;
          addr_d = mem_addr;
          err_d  = is_misaligned(mem_op, mem_addr);
          if (is_misaligned(mem_op, mem_addr)) begin
            state_d = ST_RESP;
          end else if (is_load(mem_op) || is_sub_store(mem_op)) begin
            state_d = ST_READ;
          end else if (mem_op == MEM_SW) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT: begin
        rdata_d = dmem_rdata;
        if (is_sub_store(op_q)) begin
          state_d = ST_WRITE;
        end else begin
          state_d     = ST_RESP;
          load_data_d = extract_load(op_q, addr_q[1:0], dmem_rdata);
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default:  state_d = ST_IDLE;
    endcase

    req_ready_d    = (state_d == ST_IDLE);
    rsp_valid_d    = (state_d == ST_RESP);
    misalign_err_d = (state_d == ST_RESP) && err_d;
    dmem_en_d      = (state_d == ST_READ) || (state_d == ST_WRITE);
    dmem_we_d      = (state_d == ST_WRITE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_q           <= {MEM_OP_WIDTH{1'b0}};
      addr_q         <= {CPU_WIDTH{1'b0}};
      err_q          <= 1'b0;
      rdata_q        <= {CPU_WIDTH{1'b0}};
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      misalign_err_q <= 1'b0;
      dmem_en_q      <= 1'b0;
      dmem_we_q      <= 1'b0;
      load_data_q    <= {CPU_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      misalign_err_q <= misalign_err_d;
      dmem_en_q      <= dmem_en_d;
      dmem_we_q      <= dmem_we_d;
      load_data_q    <= load_data_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign misalign_err = misalign_err_q;
  assign load_data    = load_data_q;
  assign rmw_rdata    = rdata_q;
  assign dmem_en      = dmem_en_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = {addr_q[CPU_WIDTH-1:2], 2'b00};
  assign dmem_wdata   = rmw_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: store-data mux, 1-cycle memory, transaction-level
// model checked every cycle, plus literal expectations from the test plan.
module tb_mem_access_ctrl;

  localparam logic [3:0] OP_NO  = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                         OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW  = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, misalign_err;
  logic        dmem_en, dmem_we;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, rmw_rdata, rmw_wdata, load_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] st_data;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .mem_addr(mem_addr), .rmw_rdata(rmw_rdata), .rmw_wdata(rmw_wdata),
    .rsp_valid(rsp_valid), .load_data(load_data), .misalign_err(misalign_err),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] w, input logic [31:0] sd);
    logic [31:0] mask;
    int sh;
    if (op == OP_SB) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
      return (w & ~mask) | ((sd << sh) & mask);
    end else if (op == OP_SH) begin
      sh = 16 * int'(a[1]);
      mask = 32'h0000_FFFF << sh;
      return (w & ~mask) | ((sd << sh) & mask);
    end else if (op == OP_SW) begin
      return sd;
    end else begin
      return w;
    end
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
    h = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
    case (op)
      OP_LB:   return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      OP_LHU:  return h;
      OP_LW:   return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return a[0];
    if (op == OP_LW || op == OP_SW) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Store-data mux and 1-cycle-latency memory (self-initialising on the first edge).
  assign rmw_wdata = merge(mem_op, mem_addr, rmw_rdata, st_data);

  logic [31:0] mem [0:255];
  logic [31:0] mem_rdata_q = 32'h0;
  logic        mem_init_done = 1'b0;
  assign dmem_rdata = mem_rdata_q;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[64] <= 32'hA1B2_C3D4;
      mem_init_done <= 1'b1;
    end else if (dmem_en) begin
      if (dmem_we) mem[dmem_addr[9:2]] <= dmem_wdata;
      else         mem_rdata_q <= mem[dmem_addr[9:2]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model state: shadow memory and the schedule of the current request.
  logic [31:0] mdl [0:255];
  bit          txn_act = 1'b0;
  bit          mon_en  = 1'b0;
  int          t0 = 0, lat = 0, rd_c = -1, wr_c = -1;
  logic [31:0] exp_load, exp_wdata, exp_old, exp_waddr;
  bit          exp_err, exp_sub;

  // Per-cycle compare of every output against the model schedule.
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      int  c;
      bit  busy, en_x;
      c    = cyc;
      busy = txn_act && (c > t0) && (c <= t0 + lat);
      en_x = txn_act && (c == rd_c || c == wr_c);
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(txn_act && c == t0 + lat));
      chk("dmem_en", 32'(dmem_en), 32'(en_x));
      chk("dmem_we", 32'(dmem_we & dmem_en), 32'(txn_act && c == wr_c));
      if (en_x) chk("dmem_addr", dmem_addr, exp_waddr);
      if (txn_act && c == wr_c) begin
        chk("dmem_wdata", dmem_wdata, exp_wdata);
        if (exp_sub) chk("rmw_rdata", rmw_rdata, exp_old);
      end
      if (txn_act && c == t0 + lat) begin
        chk("load_data", load_data, exp_load);
        chk("misalign_err", 32'(misalign_err), 32'(exp_err));
      end
    end
  end

  task automatic start_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd);
    int idx;
    bit ld, mis;
    @(negedge clk);
    mem_op = op; mem_addr = addr; st_data = sd; req_valid = 1'b1;
    idx       = int'(addr[9:2]);
    mis       = m_mis(op, addr);
    ld        = (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU);
    exp_sub   = (op == OP_SB || op == OP_SH);
    t0 = cyc; rd_c = -1; wr_c = -1;
    exp_old   = mdl[idx];
    exp_err   = mis;
    exp_load  = 32'h0;
    exp_waddr = {addr[31:2], 2'b00};
    exp_wdata = merge(op, addr, exp_old, sd);
    if (mis || !(ld || exp_sub || op == OP_SW)) begin
      lat = 1;
      exp_sub = 1'b0;
    end else if (ld) begin
      rd_c = t0 + 1; lat = 3; exp_load = m_load(op, addr, exp_old);
    end else if (exp_sub) begin
      rd_c = t0 + 1; wr_c = t0 + 3; lat = 4;
    end else begin
      wr_c = t0 + 1; lat = 2;
    end
    txn_act = 1'b1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input bit hold, output logic [31:0] got_load, output logic got_err);
    start_op(op, addr, sd);
    while (cyc < t0 + lat) begin
      @(negedge clk);
      if (!hold || cyc >= t0 + lat) req_valid = 1'b0;
    end
    #2;
    got_load = load_data;
    got_err  = misalign_err;
    chk("rsp_seen", 32'(rsp_valid), 32'h1);
    if (wr_c >= 0) mdl[int'(addr[9:2])] = exp_wdata;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_dmem_en"}, 32'(dmem_en), 32'h0);
    chk({tag, "_dmem_we"}, 32'(dmem_we), 32'h0);
    chk({tag, "_rmw_rdata"}, rmw_rdata, 32'h0);
    chk({tag, "_load_data"}, load_data, 32'h0);
    chk({tag, "_misalign"}, 32'(misalign_err), 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
    mdl[64] = 32'hA1B2_C3D4;
    rst_n = 1'b0; req_valid = 1'b0; mem_op = OP_NO; mem_addr = 32'h0; st_data = 32'h0;

    chk("model_lb", m_load(OP_LB, 32'h101, 32'hA1B2_C3D4), 32'hFFFF_FFC3);
    chk("model_sb", merge(OP_SB, 32'h102, 32'hA1B2_C3D4, 32'h55), 32'hA155_C3D4);

    repeat (3) @(negedge clk);
    #2;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    do_op(OP_LB,  32'h101, 32'h0, 1'b0, d, e); chk("lb_101",  d, 32'hFFFF_FFC3);
    do_op(OP_LBU, 32'h103, 32'h0, 1'b0, d, e); chk("lbu_103", d, 32'h0000_00A1);
    do_op(OP_LH,  32'h102, 32'h0, 1'b0, d, e); chk("lh_102",  d, 32'hFFFF_A1B2);
    do_op(OP_LHU, 32'h100, 32'h0, 1'b0, d, e); chk("lhu_100", d, 32'h0000_C3D4);
    do_op(OP_LW,  32'h100, 32'h0, 1'b0, d, e); chk("lw_100",  d, 32'hA1B2_C3D4);

    do_op(OP_SB,  32'h102, 32'h55, 1'b0, d, e); chk("sb_data0", d, 32'h0);
    chk("sb_mem", mem[64], 32'hA155_C3D4);
    do_op(OP_LW,  32'h100, 32'h0, 1'b0, d, e); chk("lw_after_sb", d, 32'hA155_C3D4);

    do_op(OP_SW,  32'h104, 32'hDEAD_BEEF, 1'b1, d, e); chk("sw_err", 32'(e), 32'h0);
    chk("sw_mem", mem[65], 32'hDEAD_BEEF);
    do_op(OP_LW,  32'h104, 32'h0, 1'b0, d, e); chk("lw_104", d, 32'hDEAD_BEEF);

    do_op(OP_LW,  32'h102, 32'h0, 1'b0, d, e); chk("lw_102_err", 32'(e), 32'h1);
    do_op(OP_SH,  32'h101, 32'h1234, 1'b0, d, e); chk("sh_101_err", 32'(e), 32'h1);
    chk("mis_mem", mem[64], 32'hA155_C3D4);

    do_op(OP_NO,  32'h100, 32'h0, 1'b0, d, e); chk("no_data", d, 32'h0);
    chk("no_err", 32'(e), 32'h0);
    do_op(4'hF,   32'h100, 32'h0, 1'b0, d, e); chk("unk_data", d, 32'h0);

    do_op(OP_SH,  32'h102, 32'hBEEF, 1'b0, d, e);
    do_op(OP_LH,  32'h102, 32'h0, 1'b0, d, e); chk("lh_after_sh", d, 32'hFFFF_BEEF);
    do_op(OP_LBU, 32'h100, 32'h0, 1'b0, d, e); chk("lbu_100", d, 32'h0000_00D4);

    // SH aborted by reset while the read data is being captured.
    start_op(OP_SH, 32'h100, 32'h7777);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); txn_act = 1'b0;
    #2;
    chk_reset_outputs("mid_reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk_reset_outputs("post_reset");
    repeat (3) @(negedge clk);
    chk("abort_mem", mem[64], 32'hBEEF_C3D4);
    do_op(OP_LW, 32'h100, 32'h0, 1'b0, d, e); chk("lw_after_abort", d, 32'hBEEF_C3D4);

    @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
